aes_inv_cipher: RTL and testbench

- Iterative AES-128 inverse cipher (decryptor); one round per clock.
- Takes a 128-bit ciphertext block and the original cipher key, and returns the plaintext.
- Pairs with the encryption top: ciphertext produced there, with the same key, decrypts here back to the original plaintext.
- Used behind the UART/test path to check encrypted data.

---
 rtl/aes_inv_cipher_if.sv | 29 ++
 rtl/aes_inv_cipher.sv | 272 +++++++++++++++++++++++++++
 tb/tb_aes_inv_cipher.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_inv_cipher_if.sv
// ---------------------------------------------------------------------------
// aes_inv_cipher_if
// Request/response bundle for the AES-128 inverse cipher.
//   i_valid  / o_ready : request handshake; i_cipher and i_key travel with it
//   o_valid  / i_ready : response handshake; o_plain travels with it
// Byte n of every 128-bit field sits at bits [8n:8n+7] (byte 0 leftmost),
// laid out column-major as in FIPS-197.
// master : the requester/consumer side (drives i_*)
// slave  : the decryptor side (drives o_*)
// ---------------------------------------------------------------------------
interface aes_inv_cipher_if;
  logic         i_valid;
  logic         o_ready;
  logic [0:127] i_cipher;
  logic [0:127] i_key;
  logic         o_valid;
  logic         i_ready;
  logic [0:127] o_plain;

  modport master (
    output i_valid, i_cipher, i_key, i_ready,
    input  o_ready, o_valid, o_plain
  );

  modport slave (
    input  i_valid, i_cipher, i_key, i_ready,
    output o_ready, o_valid, o_plain
  );
endinterface

// File: rtl/aes_inv_cipher.sv
// ---------------------------------------------------------------------------
// aes_inv_cipher
// Iterative AES-128 decryptor, one round per clock.
//   i_clock : system clock, rising edge
//   i_rstn  : asynchronous active-low reset
//   bus     : aes_inv_cipher_if.slave (cipher/key in, plaintext out)
// The cipher key is expanded forward to K10, then walked backward one
// round key per round while the inverse rounds run. Acceptance to o_valid
// is 21 clock edges. The two S-box lookups are the small modules
// aes_sbox / aes_inv_sbox, defined ahead of the top in this file.
// ---------------------------------------------------------------------------
package aes_inv_cipher_pkg;

  // GF(2^8) multiply, reduction polynomial 0x11b
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? (p ^ x) : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (0 maps to 0)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < 6; i++) begin
      r = gf_mul(gf_mul(r, r), a);   // a^(2^(i+2)-1)
    end
    return gf_mul(r, r);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int unsigned n);
    logic [15:0] t;
    t = {a, a} << n;
    return t[15:8];
  endfunction

endpackage

// Forward S-box: inverse in GF(2^8) followed by the affine transform
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  import aes_inv_cipher_pkg::*;
  logic [7:0] inv_s;
  assign inv_s = gf_inv(a);
  assign y = inv_s ^ rotl8(inv_s, 1) ^ rotl8(inv_s, 2) ^ rotl8(inv_s, 3)
           ^ rotl8(inv_s, 4) ^ 8'h63;
endmodule

// Inverse S-box: undo the affine transform, then invert in GF(2^8)
module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  import aes_inv_cipher_pkg::*;
  logic [7:0] pre_s;
  assign pre_s = rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05;
  assign y = gf_inv(pre_s);
endmodule

module aes_inv_cipher #(
  parameter int NR = 10
) (
  input  logic             i_clock,
  input  logic             i_rstn,
  aes_inv_cipher_if.slave  bus
);
  import aes_inv_cipher_pkg::*;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    KEYEXP   = 3'd1,
    INIT_ARK = 3'd2,
    ROUND    = 3'd3,
    FINAL    = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t       state_r, state_s;
  logic [127:0] data_r,  data_s;
  logic [127:0] key_r,   key_s;
  logic [3:0]   round_r, round_s;
  logic [127:0] plain_r, plain_s;
  logic         valid_r, valid_s;
  logic         ready_r, ready_s;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Row r of the column-major state rotates right by r bytes
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  // Key words; w3p is the recovered w3 of the previous round key
  logic [31:0] w0_s, w1_s, w2_s, w3_s, w3p_s;
  logic [31:0] sub_in_s, rot_s, sub_word_s, rcon_word_s;
  logic [31:0] w0n_s, w1n_s, w2n_s, w3n_s;
  logic [127:0] fwd_key_s, bwd_key_s;
  logic [127:0] isr_s, isb_s, ark_s, imc_s;

  assign w0_s  = key_r[127:96];
  assign w1_s  = key_r[95:64];
  assign w2_s  = key_r[63:32];
  assign w3_s  = key_r[31:0];
  assign w3p_s = w3_s ^ w2_s;

  // One SubWord serves both directions: forward expansion feeds w3,
  // the backward step feeds the recovered previous w3.
  assign sub_in_s    = (state_r == KEYEXP) ? w3_s : w3p_s;
  assign rot_s       = {sub_in_s[23:0], sub_in_s[31:24]};
  assign rcon_word_s = {rcon(round_r), 24'h000000};

  genvar g;
  for (g = 0; g < 4; g++) begin : g_sub_word
    aes_sbox u_sbox (.a(rot_s[31-8*g -: 8]), .y(sub_word_s[31-8*g -: 8]));
  end

  assign w0n_s     = w0_s ^ sub_word_s ^ rcon_word_s;
  assign w1n_s     = w1_s ^ w0n_s;
  assign w2n_s     = w2_s ^ w1n_s;
  assign w3n_s     = w3_s ^ w2n_s;
  assign fwd_key_s = {w0n_s, w1n_s, w2n_s, w3n_s};
  assign bwd_key_s = {w0_s ^ sub_word_s ^ rcon_word_s, w1_s ^ w0_s, w2_s ^ w1_s, w3p_s};

  assign isr_s = inv_shift_rows(data_r);

  for (g = 0; g < 16; g++) begin : g_inv_sub
    aes_inv_sbox u_inv_sbox (.a(isr_s[127-8*g -: 8]), .y(isb_s[127-8*g -: 8]));
  end

  // ROUND uses ark_s through InvMixColumns; FINAL takes ark_s directly
  assign ark_s = isb_s ^ key_r;
  assign imc_s = inv_mix_columns(ark_s);

  // State and datapath registers
  always_ff @(posedge i_clock or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r <= IDLE;
      data_r  <= 128'h0;
      key_r   <= 128'h0;
      round_r <= 4'd0;
      plain_r <= 128'h0;
      valid_r <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_s;
      data_r  <= data_s;
      key_r   <= key_s;
      round_r <= round_s;
      plain_r <= plain_s;
      valid_r <= valid_s;
      ready_r <= ready_s;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_s = state_r;
    data_s  = data_r;
    key_s   = key_r;
    round_s = round_r;
    plain_s = plain_r;
    valid_s = valid_r;
    ready_s = ready_r;
    case (state_r)
      IDLE: begin
        if (bus.i_valid && ready_r) begin
          data_s  = bus.i_cipher;
          key_s   = bus.i_key;
          round_s = 4'd1;
          ready_s = 1'b0;
          state_s = KEYEXP;
        end else begin
          ready_s = 1'b1;
        end
      end
      KEYEXP: begin
        key_s = fwd_key_s;
        if (round_r == 4'(NR)) begin
          state_s = INIT_ARK;       // round_r stays at NR so the first backward step uses Rcon[10]
        end else begin
          round_s = round_r + 4'd1;
        end
      end
      INIT_ARK: begin
        data_s  = data_r ^ key_r;
        key_s   = bwd_key_s;
        round_s = 4'(NR - 1);
        state_s = ROUND;
      end
      ROUND: begin
        data_s  = imc_s;
        key_s   = bwd_key_s;
        round_s = round_r - 4'd1;
        if (round_r == 4'd1) begin
          state_s = FINAL;
        end else begin
          state_s = ROUND;
        end
      end
      FINAL: begin
        plain_s = ark_s;            // key_r holds K0 here
        valid_s = 1'b1;
        state_s = DONE;
      end
      DONE: begin
        if (bus.i_ready) begin
          valid_s = 1'b0;
          ready_s = 1'b1;
          state_s = IDLE;
        end else begin
          valid_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
        ready_s = 1'b1;
      end
    endcase
  end

  assign bus.o_ready = ready_r;
  assign bus.o_valid = valid_r;
  assign bus.o_plain = plain_r;

endmodule

// File: tb/tb_aes_inv_cipher.sv
module tb_aes_inv_cipher;

  logic clk;
  logic rstn;
  aes_inv_cipher_if bus_if ();

  aes_inv_cipher #(.NR(10)) dut (
    .i_clock (clk),
    .i_rstn  (rstn),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;

  // ---------------- reference AES model (table driven, whole-block) -------
  logic [7:0] sbox_t [256];
  logic [7:0] inv_t  [256];

  function automatic logic [7:0] brotl(input logic [7:0] a, input int n);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    while (y != 8'h00) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // S-box from the generator-3 walk: p runs over powers of 3, q over their inverses
  task automatic build_tables();
    logic [7:0] p, q, x;
    p = 8'h01; q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ brotl(q, 1) ^ brotl(q, 2) ^ brotl(q, 3) ^ brotl(q, 4) ^ 8'h63;
      sbox_t[p] = x;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
    for (int i = 0; i < 256; i++) inv_t[sbox_t[i]] = 8'(i);
  endtask

  function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] v, input bit inv);
    logic [127:0] o;
    for (int n = 0; n < 16; n++)
      o[127-8*n -: 8] = inv ? inv_t[v[127-8*n -: 8]] : sbox_t[v[127-8*n -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] v, input bit inv);
    logic [127:0] o;
    int src;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
        o[127-8*(4*c+r) -: 8] = v[127-8*(4*src+r) -: 8];
      end
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] v, input bit inv);
    logic [127:0] o;
    logic [7:0]   m [4];
    logic [7:0]   acc;
    if (inv) begin m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09; end
    else     begin m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01; end
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(m[(j - i + 4) % 4], v[127-8*(4*c+j) -: 8]);
        o[127-8*(4*c+i) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] p);
    logic [127:0] s;
    s = p ^ round_key(key, 0);
    for (int r = 1; r < 10; r++) s = mix(shift_rows(sub_bytes(s, 0), 0), 0) ^ round_key(key, r);
    return shift_rows(sub_bytes(s, 0), 0) ^ round_key(key, 10);
  endfunction

  function automatic logic [127:0] aes_dec(input logic [127:0] key, input logic [127:0] c);
    logic [127:0] s;
    s = c ^ round_key(key, 10);
    for (int r = 9; r >= 1; r--) s = mix(sub_bytes(shift_rows(s, 1), 1) ^ round_key(key, r), 1);
    return sub_bytes(shift_rows(s, 1), 1) ^ round_key(key, 0);
  endfunction

  // ---------------- transaction-level model of the handshake --------------
  logic         m_ready, m_valid, m_busy;
  logic [127:0] m_plain, m_result;
  int           m_cnt;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_ready <= 1'b1; m_valid <= 1'b0; m_busy <= 1'b0;
      m_plain <= 128'h0; m_result <= 128'h0; m_cnt <= 0;
    end else if (m_ready && bus_if.i_valid) begin
      m_ready  <= 1'b0; m_busy <= 1'b1; m_cnt <= 0;
      m_result <= aes_dec(bus_if.i_key, bus_if.i_cipher);
    end else if (m_busy) begin
      if (m_cnt == 20) begin
        m_busy <= 1'b0; m_valid <= 1'b1; m_plain <= m_result;
      end
      m_cnt <= m_cnt + 1;
    end else if (m_valid && bus_if.i_ready) begin
      m_valid <= 1'b0; m_ready <= 1'b1;
    end
  end

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin
    if (rstn) begin
      checks++;
      if (bus_if.o_ready !== m_ready || bus_if.o_valid !== m_valid || bus_if.o_plain !== m_plain) begin
        failures++;
        $display("FAIL cycle_compare t=%0t ready=%b exp=%b valid=%b exp=%b plain=%h exp=%h",
                 $time, bus_if.o_ready, m_ready, bus_if.o_valid, m_valid, bus_if.o_plain, m_plain);
      end
    end
  end

  // ---------------- directed helpers --------------------------------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after acceptance
  task automatic start(input logic [127:0] k, input logic [127:0] c);
    bus_if.i_key = k; bus_if.i_cipher = c; bus_if.i_valid = 1'b1;
    @(negedge clk);
    bus_if.i_valid = 1'b0;
    bus_if.i_key = rnd128(); bus_if.i_cipher = rnd128();
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus_if.o_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (!bus_if.o_valid) check("valid_timeout", 128'(bus_if.o_valid), 128'd1);
  endtask

  task automatic accept();
    bus_if.i_ready = 1'b1;
    @(negedge clk);
    bus_if.i_ready = 1'b0;
    check("handshake_valid_low", 128'(bus_if.o_valid), 128'd0);
    check("handshake_ready_high", 128'(bus_if.o_ready), 128'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat;
    logic [127:0] k, p, c, ca, cb;

    rstn = 1'b1;
    bus_if.i_valid = 1'b0; bus_if.i_ready = 1'b0;
    bus_if.i_cipher = '0; bus_if.i_key = '0;
    build_tables();

    // Pin the model to the published vectors
    check("model_enc_appb", aes_enc(KB, PB), CB);
    check("model_dec_appb", aes_dec(KB, CB), PB);
    check("model_enc_c1",   aes_enc(KC, PC), CC);

    #2 rstn = 1'b0;
    #10;
    check("reset_ready", 128'(bus_if.o_ready), 128'd1);
    check("reset_valid", 128'(bus_if.o_valid), 128'd0);
    check("reset_plain", 128'(bus_if.o_plain), 128'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // App. B with latency and backpressure
    start(KB, CB);
    wait_valid(lat);
    check("appb_latency", 128'(lat), 128'd21);
    check("appb_plain", bus_if.o_plain, PB);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("bp_valid", 128'(bus_if.o_valid), 128'd1);
      check("bp_plain", bus_if.o_plain, PB);
      check("bp_ready", 128'(bus_if.o_ready), 128'd0);
    end
    accept();
    check("retain_plain", bus_if.o_plain, PB);

    // C.1 with an ignored request pulsed at E5
    start(KC, CC);
    repeat (4) @(negedge clk);
    bus_if.i_valid = 1'b1; bus_if.i_cipher = CB; bus_if.i_key = KB;
    @(negedge clk);
    bus_if.i_valid = 1'b0;
    wait_valid(lat);
    check("c1_plain_busy_ignored", bus_if.o_plain, PC);
    accept();

    // Back-to-back with i_valid held high
    k = rnd128(); ca = rnd128(); cb = rnd128();
    bus_if.i_key = k; bus_if.i_cipher = ca; bus_if.i_valid = 1'b1; bus_if.i_ready = 1'b1;
    @(negedge clk);
    bus_if.i_cipher = cb;
    wait_valid(lat);
    check("b2b_first_latency", 128'(lat), 128'd21);
    check("b2b_first_plain", bus_if.o_plain, aes_dec(k, ca));
    @(negedge clk);
    check("b2b_ready_after_hs", 128'(bus_if.o_ready), 128'd1);
    check("b2b_valid_after_hs", 128'(bus_if.o_valid), 128'd0);
    @(negedge clk);
    check("b2b_second_accepted", 128'(bus_if.o_ready), 128'd0);
    bus_if.i_valid = 1'b0;
    wait_valid(lat);
    check("b2b_second_latency", 128'(lat), 128'd21);
    check("b2b_second_plain", bus_if.o_plain, aes_dec(k, cb));
    @(negedge clk);
    bus_if.i_ready = 1'b0;
    check("b2b_final_ready", 128'(bus_if.o_ready), 128'd1);

    // Reset at E15 aborts the operation
    start(KC, CC);
    repeat (14) @(negedge clk);
    @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check("midrst_valid", 128'(bus_if.o_valid), 128'd0);
    check("midrst_plain", 128'(bus_if.o_plain), 128'h0);
    check("midrst_ready", 128'(bus_if.o_ready), 128'd1);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    start(KB, CB);
    wait_valid(lat);
    check("post_rst_latency", 128'(lat), 128'd21);
    check("post_rst_plain", bus_if.o_plain, PB);
    accept();

    // Random round trips through the model's encryptor
    for (int n = 0; n < 4; n++) begin
      k = rnd128(); p = rnd128();
      c = aes_enc(k, p);
      start(k, c);
      wait_valid(lat);
      check("roundtrip_plain", bus_if.o_plain, p);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      accept();
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
